// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS front end: load-use, jump, taken-branch and IMEM wait handling.
// Build macro HAZARD_PERF_CNT_EN adds the stall_count/flush_count performance counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int IMEM_TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset_in,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rt,
  input  logic        jump_id,
  input  logic        branch_taken_ex,
  input  logic        imem_ready,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        flush_jump,
  output logic        flush_branch,
  output logic        id_ex_bubble,
  output logic        stall_active,
`ifdef HAZARD_PERF_CNT_EN
  output logic        imem_error,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
`else
  output logic        imem_error
`endif
);

  typedef enum logic [1:0] {RUN, STALL, IMEM_WAIT} state_t;

  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] TIMEOUT    = 8'(IMEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [2:0] stall_cnt, stall_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       imem_error_nxt;
  logic       load_use;
  logic       hold;

  assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));

  // imem_ready is sampled every cycle; a fetch completes in any cycle where it is high.
  always_comb begin
    hold           = 1'b0;
    flush_jump     = 1'b0;
    flush_branch   = 1'b0;
    stall_active   = (state != RUN);
    state_nxt      = state;
    stall_cnt_nxt  = stall_cnt;
    wait_cnt_nxt   = wait_cnt;
    imem_error_nxt = imem_error;
    if (reset_in) begin
      hold           = 1'b1;
      stall_active   = 1'b0;
      state_nxt      = RUN;
      stall_cnt_nxt  = 3'd0;
      wait_cnt_nxt   = 8'd0;
      imem_error_nxt = 1'b0;
    end else if (branch_taken_ex) begin
      flush_branch  = 1'b1;
      state_nxt     = RUN;
      stall_cnt_nxt = 3'd0;
      wait_cnt_nxt  = 8'd0;
    end else if (state == STALL) begin
      hold = 1'b1;
      if (stall_cnt <= 3'd1) begin
        state_nxt     = RUN;
        stall_cnt_nxt = 3'd0;
      end else begin
        stall_cnt_nxt = stall_cnt - 3'd1;
      end
    end else if (state == IMEM_WAIT && !imem_ready) begin
      hold         = 1'b1;
      wait_cnt_nxt = (wait_cnt == 8'd255) ? 8'd255 : wait_cnt + 8'd1;
      if (wait_cnt_nxt >= TIMEOUT) imem_error_nxt = 1'b1;
    end else begin
      // RUN, or the cycle in which a pending fetch finally completes.
      state_nxt    = RUN;
      wait_cnt_nxt = 8'd0;
      if (jump_id) begin
        flush_jump = 1'b1;
      end else if (load_use) begin
        hold = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          state_nxt     = STALL;
          stall_cnt_nxt = STALL_INIT;
        end
      end else if (!imem_ready) begin
        hold         = 1'b1;
        state_nxt    = IMEM_WAIT;
        wait_cnt_nxt = 8'd1;
      end
    end
    pc_enable    = !hold;
    if_id_enable = !hold;
    id_ex_bubble = hold || flush_branch;
  end

  always_ff @(posedge clk) begin
    state      <= state_nxt;
    stall_cnt  <= stall_cnt_nxt;
    wait_cnt   <= wait_cnt_nxt;
    imem_error <= imem_error_nxt;
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset_in) begin
      stall_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (id_ex_bubble && !flush_jump && !flush_branch) stall_count <= stall_count + 32'd1;
      if (flush_jump || flush_branch) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: table vectors, hand sequences and random stimulus against a cycle model.
// Two instances run side by side: defaults (1 bubble, timeout 16) and 3 bubbles with timeout 4.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_in;
  logic [4:0] id_rs, id_rt, id_ex_rt;
  logic       id_uses_rt, id_ex_mem_read, jump_id, branch_taken_ex, imem_ready;
  logic       pc0, ifid0, fj0, fb0, bub0, sa0, err0;
  logic       pc1, ifid1, fj1, fb1, bub1, sa1, err1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] sc0, fc0, sc1, fc1;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .IMEM_TIMEOUT(16)) u0 (
    .clk(clk), .reset_in(reset_in), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .jump_id(jump_id),
    .branch_taken_ex(branch_taken_ex), .imem_ready(imem_ready), .pc_enable(pc0),
    .if_id_enable(ifid0), .flush_jump(fj0), .flush_branch(fb0), .id_ex_bubble(bub0),
    .stall_active(sa0),
`ifdef HAZARD_PERF_CNT_EN
    .stall_count(sc0), .flush_count(fc0),
`endif
    .imem_error(err0));

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .IMEM_TIMEOUT(4)) u1 (
    .clk(clk), .reset_in(reset_in), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .jump_id(jump_id),
    .branch_taken_ex(branch_taken_ex), .imem_ready(imem_ready), .pc_enable(pc1),
    .if_id_enable(ifid1), .flush_jump(fj1), .flush_branch(fb1), .id_ex_bubble(bub1),
    .stall_active(sa1),
`ifdef HAZARD_PERF_CNT_EN
    .stall_count(sc1), .flush_count(fc1),
`endif
    .imem_error(err1));

  // Output vectors packed as {pc_enable, if_id_enable, flush_jump, flush_branch, id_ex_bubble, stall_active, imem_error}
  logic [6:0] act [2];
  assign act[0] = {pc0, ifid0, fj0, fb0, bub0, sa0, err0};
  assign act[1] = {pc1, ifid1, fj1, fb1, bub1, sa1, err1};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: remaining stall bubbles, pending-fetch flag, consecutive wait count, sticky error.
  int lsc_p [2] = '{1, 3};
  int to_p  [2] = '{16, 4};
  int m_stall [2], m_wait [2], m_wcnt [2], m_err [2];
  int n_stall [2], n_wait [2], n_wcnt [2], n_err [2];
  logic [6:0] exp_q [$];

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       urt, mr;
    logic [4:0] exrt;
    logic       j, b, rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic urt, logic mr,
                              logic [4:0] exrt, logic j, logic b, logic rdy, logic [6:0] exp);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.urt = urt; v.mr = mr;
    v.exrt = exrt; v.j = j; v.b = b; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic chk(string name, logic [6:0] got, logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic chk1(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; the trailing #4 lands on the falling edge.
  task automatic drive(logic rst, logic [4:0] rs, logic [4:0] rt, logic urt, logic mr,
                       logic [4:0] exrt, logic j, logic b, logic rdy);
    reset_in = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_ex_mem_read = mr;
    id_ex_rt = exrt; jump_id = j; branch_taken_ex = b; imem_ready = rdy;
    #4;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic model_eval(int k);
    logic lu, pc, ifid, fj, fb, bub, sa;
    lu = id_ex_mem_read && id_ex_rt != 0 &&
         (id_ex_rt == id_rs || (id_uses_rt && id_ex_rt == id_rt));
    pc = 1; ifid = 1; fj = 0; fb = 0; bub = 0;
    sa = (m_stall[k] > 0) || (m_wait[k] != 0);
    n_stall[k] = m_stall[k]; n_wait[k] = m_wait[k]; n_wcnt[k] = m_wcnt[k]; n_err[k] = m_err[k];
    if (reset_in) begin
      pc = 0; ifid = 0; bub = 1; sa = 0;
      n_stall[k] = 0; n_wait[k] = 0; n_wcnt[k] = 0; n_err[k] = 0;
    end else if (branch_taken_ex) begin
      fb = 1; bub = 1;
      n_stall[k] = 0; n_wait[k] = 0; n_wcnt[k] = 0;
    end else if (m_stall[k] > 0) begin
      pc = 0; ifid = 0; bub = 1;
      n_stall[k] = m_stall[k] - 1;
    end else if (m_wait[k] != 0 && !imem_ready) begin
      pc = 0; ifid = 0; bub = 1;
      n_wcnt[k] = (m_wcnt[k] + 1 > 255) ? 255 : m_wcnt[k] + 1;
      if (n_wcnt[k] >= to_p[k]) n_err[k] = 1;
    end else begin
      n_wait[k] = 0; n_wcnt[k] = 0;
      if (jump_id) fj = 1;
      else if (lu) begin
        pc = 0; ifid = 0; bub = 1;
        n_stall[k] = lsc_p[k] - 1;
      end else if (!imem_ready) begin
        pc = 0; ifid = 0; bub = 1;
        n_wait[k] = 1; n_wcnt[k] = 1;
      end
    end
    exp_q.push_back({pc, ifid, fj, fb, bub, sa, logic'(m_err[k] != 0)});
  endtask

  // Compare both instances with the model, then cross the rising edge.
  task automatic step();
    logic [6:0] e;
    for (int k = 0; k < 2; k++) model_eval(k);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      chk(k == 0 ? "model_u0" : "model_u1", act[k], e);
    end
    @(posedge clk);
    m_stall = n_stall; m_wait = n_wait; m_wcnt = n_wcnt; m_err = n_err;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int outage;
    // Bring both instances out of their unknown power-up state before any checking.
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_stall[k] = 0; m_wait[k] = 0; m_wcnt[k] = 0; m_err[k] = 0;
    end

    // rst rs rt urt mr exrt j b rdy | {pc, ifid, fj, fb, bub, sa, err} for the default instance
    tbl[0]  = mk(1, 0,  0, 0, 0, 0,  0, 0, 1, 7'b0000100);
    tbl[1]  = mk(1, 0,  0, 0, 0, 0,  0, 0, 1, 7'b0000100);
    tbl[2]  = mk(0, 0,  0, 0, 0, 0,  0, 0, 1, 7'b1100000);
    tbl[3]  = mk(0, 10, 0, 0, 1, 10, 0, 0, 1, 7'b0000100);
    tbl[4]  = mk(0, 0,  0, 0, 0, 0,  0, 0, 1, 7'b1100000);
    tbl[5]  = mk(0, 0,  0, 0, 1, 0,  0, 0, 1, 7'b1100000);
    tbl[6]  = mk(0, 3, 18, 0, 1, 18, 0, 0, 1, 7'b1100000);
    tbl[7]  = mk(0, 3, 18, 1, 1, 18, 0, 0, 1, 7'b0000100);
    tbl[8]  = mk(0, 0,  0, 0, 0, 0,  1, 0, 1, 7'b1110000);
    tbl[9]  = mk(0, 10, 0, 0, 1, 10, 1, 0, 1, 7'b1110000);
    tbl[10] = mk(0, 10, 0, 0, 1, 10, 0, 1, 1, 7'b1101100);
    tbl[11] = mk(0, 0,  0, 0, 0, 0,  0, 0, 0, 7'b0000100);
    tbl[12] = mk(0, 0,  0, 0, 0, 0,  0, 0, 0, 7'b0000110);
    tbl[13] = mk(0, 0,  0, 0, 0, 0,  0, 0, 1, 7'b1100010);
    tbl[14] = mk(0, 0,  0, 0, 0, 0,  0, 0, 1, 7'b1100000);
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].rs, tbl[i].rt, tbl[i].urt, tbl[i].mr,
            tbl[i].exrt, tbl[i].j, tbl[i].b, tbl[i].rdy);
      chk($sformatf("table_%0d", i), act[0], tbl[i].exp);
      step();
    end

    // Three-bubble load-use with the hazard held on the inputs for the whole stall.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd10, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b1);
      chk1($sformatf("lu3_pc_%0d", i), pc1, 1'b0);
      chk1($sformatf("lu3_bubble_%0d", i), bub1, 1'b1);
      chk1($sformatf("lu3_active_%0d", i), sa1, i != 0);
      step();
    end
    idle();
    chk1("lu3_release_pc", pc1, 1'b1);
    chk1("lu3_release_active", sa1, 1'b0);
    step();

    // Taken branch in the second stall cycle overrides the stall.
    do_reset();
    drive(1'b0, 5'd10, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b1);
    chk1("brov_stall_pc", pc1, 1'b0);
    step();
    drive(1'b0, 5'd10, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b1, 1'b1);
    chk1("brov_flush_branch", fb1, 1'b1);
    chk1("brov_bubble", bub1, 1'b1);
    chk1("brov_pc", pc1, 1'b1);
    step();
    idle();
    chk1("brov_after_pc", pc1, 1'b1);
    chk1("brov_after_active", sa1, 1'b0);
    chk1("brov_after_flush", fb1, 1'b0);
    step();

    // Twenty cycles without instruction data on the default instance (timeout 16).
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk1($sformatf("imem_pc_%0d", i), pc0, 1'b0);
      chk1($sformatf("imem_active_%0d", i), sa0, i >= 2);
      chk1($sformatf("imem_error_%0d", i), err0, i >= 17);
      step();
    end
    idle();
    chk1("imem_done_pc", pc0, 1'b1);
    chk1("imem_done_error", err0, 1'b1);
    step();
    idle();
    chk1("imem_sticky_error", err0, 1'b1);
    chk1("imem_sticky_active", sa0, 1'b0);
    step();
    do_reset();
    idle();
    chk1("imem_error_cleared", err0, 1'b0);
    step();

    // Random traffic with occasional fetch outages and resets.
    outage = 0;
    for (int i = 0; i < 600; i++) begin
      logic rdy;
      if (outage > 0) begin
        rdy = 1'b0;
        outage--;
      end else begin
        rdy = ($urandom_range(0, 99) < 80);
        if ($urandom_range(0, 99) < 3) outage = $urandom_range(3, 20);
      end
      drive($urandom_range(0, 99) < 2, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 99) < 40, 5'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 8, rdy);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
